// File: rtl/imm_decode_ctrl_if.sv
// Fetch-to-decode handshake and head-entry bus for imm_decode_ctrl.
// The slave modport is the controller; the master modport is fetch/execute.
interface imm_decode_ctrl_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] in_inst;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [24:0]       out_imm_src;
    logic [2:0]        out_imm_sel;
    logic [INST_W-1:0] out_inst;
    logic [PC_W-1:0]   out_pc;
    logic              out_illegal;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_imm_src, out_imm_sel, out_inst, out_pc, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_imm_src, out_imm_sel, out_inst, out_pc, out_illegal
    );
endinterface

// File: rtl/imm_decode_ctrl.sv
// Decode-stage controller: 2-entry skid FIFO feeding the RV32I sign-extend unit.
// Optional ILLEGAL_DET_EN adds a per-entry illegal-opcode flag on out_illegal.
module imm_decode_ctrl #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    imm_decode_ctrl_if.slave      bus
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]        count;
    logic [1:0]        count_nxt;
    logic              wr_ptr;
    logic              rd_ptr;
    logic              in_ready_q;
    logic              out_valid;
    logic              push;
    logic              pop;

    logic [INST_W-1:0] mem_inst [2];
    logic [PC_W-1:0]   mem_pc   [2];
    logic [2:0]        mem_sel  [2];
`ifdef ILLEGAL_DET_EN
    logic              mem_ill  [2];
`endif

    function automatic logic [2:0] imm_sel_of(input logic [INST_W-1:0] inst);
        logic [2:0] sel;
        case (inst[6:0])
            7'b0000011, 7'b1100111: sel = 3'd0;
            7'b0010011: begin
                case (inst[14:12])
                    3'b011:         sel = 3'd1;
                    3'b001, 3'b101: sel = 3'd2;
                    default:        sel = 3'd0;
                endcase
            end
            7'b0100011:             sel = 3'd3;
            7'b1100011:             sel = 3'd4;
            7'b0110111, 7'b0010111: sel = 3'd5;
            7'b1101111:             sel = 3'd6;
            default:                sel = 3'd7;
        endcase
        return sel;
    endfunction

`ifdef ILLEGAL_DET_EN
    function automatic logic illegal_of(input logic [INST_W-1:0] inst);
        logic ill;
        case (inst[6:0])
            7'b0000011, 7'b0010011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b1100111,
            7'b1101111, 7'b0110111, 7'b0010111, 7'b0001111, 7'b1110011: ill = 1'b0;
            default:                                                    ill = 1'b1;
        endcase
        return ill;
    endfunction
`endif

    assign out_valid = (count != EMPTY);
    assign push      = bus.in_valid & in_ready_q;
    assign pop       = out_valid & bus.out_ready;

    // A FULL FIFO never sees push, since in_ready_q already dropped the cycle it filled.
    always_comb begin
        count_nxt = count;
        if (flush)
            count_nxt = EMPTY;
        else if (push && !pop)
            count_nxt = count + ONE;
        else if (pop && !push)
            count_nxt = count - ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= EMPTY;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            count      <= count_nxt;
            in_ready_q <= (count_nxt != FULL);
            if (flush) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= ~wr_ptr;
                if (pop)
                    rd_ptr <= ~rd_ptr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_inst <= '{default: '0};
            mem_pc   <= '{default: '0};
            mem_sel  <= '{default: '0};
`ifdef ILLEGAL_DET_EN
            mem_ill  <= '{default: '0};
`endif
        end else if (push && !flush) begin
            mem_inst[wr_ptr] <= bus.in_inst;
            mem_pc[wr_ptr]   <= bus.in_pc;
            mem_sel[wr_ptr]  <= imm_sel_of(bus.in_inst);
`ifdef ILLEGAL_DET_EN
            mem_ill[wr_ptr]  <= illegal_of(bus.in_inst);
`endif
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid;
    assign bus.out_inst    = mem_inst[rd_ptr];
    assign bus.out_imm_src = mem_inst[rd_ptr][31:7];
    assign bus.out_imm_sel = mem_sel[rd_ptr];
    assign bus.out_pc      = mem_pc[rd_ptr];
`ifdef ILLEGAL_DET_EN
    assign bus.out_illegal = mem_ill[rd_ptr];
`else
    assign bus.out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Self-checking bench for imm_decode_ctrl: vector table plus hand sequences, scoreboarded.
module tb_imm_decode_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    imm_decode_ctrl_if #(.PC_W(32), .INST_W(32)) bus ();

    imm_decode_ctrl #(.PC_W(32), .INST_W(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

`ifdef ILLEGAL_DET_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  sel;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [2:0]  sel;
        logic        ill;
    } exp_t;

    vec_t  vecs [18];
    exp_t  sbq [$];
    int    checks = 0;
    int    errors = 0;
    logic [2:0] cur_sel;
    logic       cur_ill;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                         input logic [2:0] sel, input logic ill);
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_pc    = pc;
        cur_sel      = sel;
        cur_ill      = ill;
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] pc,
                        input logic [2:0] sel, input logic ill);
        int unsigned t = 0;
        drive(inst, pc, sel, ill);
        while (!bus.in_ready && t < 50) begin
            bus.out_ready = 1'b1;
            step();
            t++;
        end
        if (t >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 for %0d cycles expected accept", t);
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    // Output handshake is checked before input so a same-cycle push never matches itself.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got inst 0x%08h expected none", bus.out_inst);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("out_inst", bus.out_inst, e.inst);
                    chk("out_pc", bus.out_pc, e.pc);
                    chk("out_imm_src", 32'(bus.out_imm_src), 32'(e.inst[31:7]));
                    chk("out_imm_sel", 32'(bus.out_imm_sel), 32'(e.sel));
                    chk("out_illegal", 32'(bus.out_illegal), 32'(e.ill & ILL_EN));
                end
            end
            if (flush)
                sbq.delete();
            else if (bus.in_valid && bus.in_ready)
                sbq.push_back('{bus.in_inst, bus.in_pc, cur_sel, cur_ill});
        end
    end

    initial begin
        vecs[0]  = '{32'h00500093, 3'd0, 1'b0};  // addi
        vecs[1]  = '{32'h00002083, 3'd0, 1'b0};  // lw
        vecs[2]  = '{32'h00008067, 3'd0, 1'b0};  // jalr
        vecs[3]  = '{32'h00002013, 3'd0, 1'b0};  // slti
        vecs[4]  = '{32'h00007013, 3'd0, 1'b0};  // andi
        vecs[5]  = '{32'h00003013, 3'd1, 1'b0};  // sltiu
        vecs[6]  = '{32'h00001013, 3'd2, 1'b0};  // slli
        vecs[7]  = '{32'h40005013, 3'd2, 1'b0};  // srai
        vecs[8]  = '{32'h00112023, 3'd3, 1'b0};  // sw
        vecs[9]  = '{32'hFE208EE3, 3'd4, 1'b0};  // beq
        vecs[10] = '{32'h12345037, 3'd5, 1'b0};  // lui
        vecs[11] = '{32'h00000017, 3'd5, 1'b0};  // auipc
        vecs[12] = '{32'h008000EF, 3'd6, 1'b0};  // jal
        vecs[13] = '{32'h002081B3, 3'd7, 1'b0};  // add
        vecs[14] = '{32'h00000073, 3'd7, 1'b0};  // ecall
        vecs[15] = '{32'h0000000F, 3'd7, 1'b0};  // fence
        vecs[16] = '{32'h0000007F, 3'd7, 1'b1};  // illegal opcode
        vecs[17] = '{32'h00000000, 3'd7, 1'b1};  // all-zero

        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_inst = '0;
        bus.in_pc = '0;
        bus.out_ready = 1'b0;
        cur_sel = '0;
        cur_ill = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_imm_sel", 32'(bus.out_imm_sel), 32'd0);
        chk("rst_imm_src", 32'(bus.out_imm_src), 32'd0);
        chk("rst_out_inst", bus.out_inst, 32'd0);
        chk("rst_out_pc", bus.out_pc, 32'd0);
        chk("rst_illegal", 32'(bus.out_illegal), 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // single addi: visible the cycle after the push
        drive(32'h00500093, 32'h100, 3'd0, 1'b0);
        step();
        bus.in_valid = 1'b0;
        chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_imm_sel", 32'(bus.out_imm_sel), 32'd0);
        chk("lat_imm_src", 32'(bus.out_imm_src), 32'h000A001);
        bus.out_ready = 1'b1;
        step();
        chk("lat_drained", 32'(bus.out_valid), 32'd0);

        // beq then jal back to back
        drive(32'hFE208EE3, 32'h104, 3'd4, 1'b0);
        step();
        chk("b2b_sel_beq", 32'(bus.out_imm_sel), 32'd4);
        drive(32'h008000EF, 32'h108, 3'd6, 1'b0);
        step();
        bus.in_valid = 1'b0;
        chk("b2b_sel_jal", 32'(bus.out_imm_sel), 32'd6);
        step();
        chk("b2b_drained", 32'(bus.out_valid), 32'd0);

        // stall: fill, third held by fetch, then FULL pop with in_valid
        bus.out_ready = 1'b0;
        drive(32'h00002083, 32'h200, 3'd0, 1'b0);
        step();
        drive(32'h00112023, 32'h204, 3'd3, 1'b0);
        step();
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        drive(32'h00000017, 32'h208, 3'd5, 1'b0);
        repeat (3) step();
        chk("full_in_ready_held", 32'(bus.in_ready), 32'd0);
        chk("full_head_stable", bus.out_inst, 32'h00002083);
        bus.out_ready = 1'b1;
        step();
        chk("fullpop_head", bus.out_inst, 32'h00112023);
        chk("fullpop_in_ready", 32'(bus.in_ready), 32'd1);
        chk("fullpop_out_valid", 32'(bus.out_valid), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk("stall_third_head", bus.out_inst, 32'h00000017);
        step();
        chk("stall_drained", 32'(bus.out_valid), 32'd0);

        // flush with a push pending: nothing survives, lui never emitted
        bus.out_ready = 1'b0;
        drive(32'h00002083, 32'h300, 3'd0, 1'b0);
        step();
        drive(32'h00112023, 32'h304, 3'd3, 1'b0);
        step();
        flush = 1'b1;
        drive(32'h12345037, 32'h308, 3'd5, 1'b0);
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        repeat (3) step();
        chk("flush_no_emit", 32'(bus.out_valid), 32'd0);

        // flush together with pop: head completes, second entry dropped
        bus.out_ready = 1'b0;
        drive(32'h00500093, 32'h400, 3'd0, 1'b0);
        step();
        drive(32'h008000EF, 32'h404, 3'd6, 1'b0);
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flushpop_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (2) step();

        // asynchronous reset mid-operation
        bus.out_ready = 1'b0;
        drive(32'h00003013, 32'h500, 3'd1, 1'b0);
        step();
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        sbq.delete();
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_out_inst", bus.out_inst, 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("async_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // vector table with randomised back-pressure
        for (int i = 0; i < 18; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            send(vecs[i].inst, 32'h1000 + 32'(4 * i), vecs[i].sel, vecs[i].ill);
        end
        bus.out_ready = 1'b1;
        for (int t = 0; t < 50 && sbq.size() != 0; t++)
            step();
        step();
        chk("drain_queue_empty", 32'(sbq.size()), 32'd0);
        chk("drain_out_valid", 32'(bus.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
